// File: rtl/piso_pkg.sv
// Shared constants and helpers for the PISO/SIPO serialiser family.
package piso_pkg;

  localparam int PISO_LSB_FIRST = 0;
  localparam int PISO_MSB_FIRST = 1;

  // Bit-counter width needed to hold (WIDTH - 1).
  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_param.sv
// Parametrised parallel-in/serial-out shifter with a valid/ready load port and stallable serial side.
// A word offered during the last bit of a frame is accepted on that edge, giving gapless frames.
module piso_shift_param
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = PISO_LSB_FIRST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy
);

  localparam int CNT_W = piso_cnt_w(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CNT_W-1:0] cnt;
  logic             vld;
  logic             last_bit;
  logic             accept;
  logic             consume;

  assign last_bit   = (cnt == '0);
  assign load_ready = reset && (!vld || (shift_en && last_bit));
  assign accept     = load_valid && load_ready;
  assign consume    = vld && shift_en;

  assign sr_shifted = (MSB_FIRST == PISO_MSB_FIRST) ? {sr[WIDTH-2:0], 1'b0}
                                                    : {1'b0, sr[WIDTH-1:1]};

  // Outputs are forced low as soon as reset is held, before the clearing edge.
  assign serial_valid = reset && vld;
  assign serial_out   = serial_valid &&
                        ((MSB_FIRST == PISO_MSB_FIRST) ? sr[WIDTH-1] : sr[0]);
  assign serial_last  = serial_valid && last_bit;
  assign busy         = serial_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
      vld <= 1'b0;
    end else if (accept) begin
      sr  <= load_data;
      cnt <= CNT_W'(WIDTH - 1);
      vld <= 1'b1;
    end else if (consume) begin
      if (!last_bit) begin
        sr  <= sr_shifted;
        cnt <= cnt - CNT_W'(1);
      end else begin
        sr  <= '0;
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// Scoreboard bench for piso_shift_param: WIDTH 8/12 in both bit orders.
module tb_piso_shift_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic        shift_en = 1'b0;
  logic [11:0] load_data = '0;
  logic [3:0]  rdy, sout, svld, slast, sbusy;

  int sel = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  always #5 clock = ~clock;

  piso_shift_param #(.WIDTH(8), .MSB_FIRST(0)) u_w8_lsb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[0]),
    .load_data(load_data[7:0]), .shift_en(shift_en), .serial_out(sout[0]),
    .serial_valid(svld[0]), .serial_last(slast[0]), .busy(sbusy[0]));
  piso_shift_param #(.WIDTH(8), .MSB_FIRST(1)) u_w8_msb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[1]),
    .load_data(load_data[7:0]), .shift_en(shift_en), .serial_out(sout[1]),
    .serial_valid(svld[1]), .serial_last(slast[1]), .busy(sbusy[1]));
  piso_shift_param #(.WIDTH(12), .MSB_FIRST(0)) u_w12_lsb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[2]),
    .load_data(load_data), .shift_en(shift_en), .serial_out(sout[2]),
    .serial_valid(svld[2]), .serial_last(slast[2]), .busy(sbusy[2]));
  piso_shift_param #(.WIDTH(12), .MSB_FIRST(1)) u_w12_msb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[3]),
    .load_data(load_data), .shift_en(shift_en), .serial_out(sout[3]),
    .serial_valid(svld[3]), .serial_last(slast[3]), .busy(sbusy[3]));

  logic m_rdy, m_out, m_vld, m_last, m_busy;
  assign m_rdy  = rdy[sel];
  assign m_out  = sout[sel];
  assign m_vld  = svld[sel];
  assign m_last = slast[sel];
  assign m_busy = sbusy[sel];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected {bit, last} per consumed bit, in transmission order.
  function automatic void push_frame(input logic [11:0] w, input int width, input bit msb);
    for (int i = 0; i < width; i++) begin
      int idx;
      idx = msb ? (width - 1 - i) : i;
      exp_q.push_back({w[idx], (i == width - 1) ? 1'b1 : 1'b0});
    end
  endfunction

  // Every consumed bit is popped and compared; idle output must read 0.
  always @(negedge clock) begin
    if (m_vld && shift_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_bit", 1, 0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("sb_bit_last", {m_out, m_last}, e);
      end
    end
    if (!m_vld) chk("idle_out", m_out, 0);
  end

  task automatic do_reset(input int s);
    reset = 1'b0;
    load_valid = 1'b0;
    shift_en = 1'b1;
    sel = s;
    exp_q.delete();
    step();
    @(negedge clock);
    chk("rst_vld", m_vld, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_rdy", m_rdy, 0);
    step();
    reset = 1'b1;
  endtask

  task automatic run_frame(input int s, input logic [11:0] w, input int width, input bit msb);
    do_reset(s);
    load_valid = 1'b1;
    load_data = w;
    push_frame(w, width, msb);
    @(negedge clock);
    chk("rdy_idle", m_rdy, 1);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= width; c++) begin
      @(negedge clock);
      chk("frm_vld", m_vld, 1);
      chk("frm_busy", m_busy, 1);
      chk("frm_last", m_last, (c == width));
      chk("frm_rdy", m_rdy, (c == width));
      step();
    end
    @(negedge clock);
    chk("frm_end_vld", m_vld, 0);
    chk("frm_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Test 1: WIDTH 8, LSB-first, 8'b0101_1100.
    run_frame(0, 12'h05C, 8, 1'b0);

    // Test 2: WIDTH 8, MSB-first, CC then 5C back-to-back.
    do_reset(1);
    load_valid = 1'b1;
    load_data = 12'h0CC;
    push_frame(12'h0CC, 8, 1'b1);
    step();
    load_data = 12'h05C;
    push_frame(12'h05C, 8, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      chk("b2b_vld", m_vld, 1);
      chk("b2b_last", m_last, (c == 8 || c == 16));
      if (c == 8) chk("b2b_rdy8", m_rdy, 1);
      step();
      if (c == 8) load_valid = 1'b0;
    end
    @(negedge clock);
    chk("b2b_end_vld", m_vld, 0);
    chk("b2b_q_empty", exp_q.size(), 0);

    // Test 3: stall on cycles 2-3, frame ends on cycle 10.
    do_reset(0);
    load_valid = 1'b1;
    load_data = 12'h001;
    push_frame(12'h001, 8, 1'b0);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      shift_en = !(c == 2 || c == 3);
      @(negedge clock);
      chk("stl_vld", m_vld, 1);
      chk("stl_last", m_last, (c == 10));
      if (c == 2 || c == 3) begin
        chk("stl_out_hold", m_out, 0);
        chk("stl_rdy", m_rdy, 0);
      end
      step();
    end
    shift_en = 1'b1;
    @(negedge clock);
    chk("stl_end_vld", m_vld, 0);
    chk("stl_q_empty", exp_q.size(), 0);

    // Test 4: reset mid-frame, then a fresh frame.
    do_reset(0);
    load_valid = 1'b1;
    load_data = 12'h0FF;
    push_frame(12'h0FF, 8, 1'b0);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      chk("rm_vld", m_vld, 1);
      step();
    end
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("rm_held_vld", m_vld, 0);
    chk("rm_held_rdy", m_rdy, 0);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("rm_after_out", m_out, 0);
    chk("rm_after_vld", m_vld, 0);
    chk("rm_after_rdy", m_rdy, 1);
    load_valid = 1'b1;
    load_data = 12'h0A5;
    push_frame(12'h0A5, 8, 1'b0);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      chk("rm_new_vld", m_vld, 1);
      step();
    end
    @(negedge clock);
    chk("rm_end_vld", m_vld, 0);
    chk("rm_q_empty", exp_q.size(), 0);

    // Test 5: load offered while busy is ignored.
    do_reset(0);
    load_valid = 1'b1;
    load_data = 12'h00F;
    push_frame(12'h00F, 8, 1'b0);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        load_valid = 1'b1;
        load_data = 12'h0F0;
      end else begin
        load_valid = 1'b0;
      end
      @(negedge clock);
      if (c == 3) chk("ign_rdy", m_rdy, 0);
      chk("ign_vld", m_vld, 1);
      step();
    end
    load_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("ign_idle_vld", m_vld, 0);
      step();
    end
    chk("ign_q_empty", exp_q.size(), 0);

    // Test 6: WIDTH 12 in both orders.
    run_frame(2, 12'hABC, 12, 1'b0);
    run_frame(3, 12'hABC, 12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_shift_param.md
Name: piso_shift_param

Overview:
Parametrised parallel-in/serial-out shifter, the successor to the fixed 8-bit PISO.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Serialises the word one bit per enabled clock, LSB-first or MSB-first.
- Flags each valid bit and the last bit of every frame.
- Supports gapless back-to-back frames and output-side stall.
- Sits between a parallel datapath and a serial link or test pin.

Parameters:
WIDTH, 8, bits per frame; legal range 2..64.
MSB_FIRST, 0, 0 = shift out bit 0 first; 1 = shift out bit WIDTH-1 first.
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clock.
load_valid  input  1  load_data is offered this cycle.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word; captured when load_valid && load_ready at a posedge.
shift_en  input  1  downstream consumes the current bit this cycle (stall when 0).
serial_out  output  1  current serial bit; 0 whenever serial_valid is 0.
serial_valid  output  1  serial_out holds a frame bit.
serial_last  output  1  serial_valid && current bit is the final bit of the frame.
busy  output  1  equals serial_valid; provided for status.

Behaviour:
- Reset: when reset == 0 at a posedge, clear the shift register and counter to 0 and clear serial_valid. This overrides all other inputs and discards any frame in flight. While reset is low: serial_out = 0, serial_valid = 0, serial_last = 0, busy = 0, load_ready = 0.
- State: shift register sr[WIDTH-1:0], counter cnt[CNT_W-1:0] (bits remaining minus 1), flag serial_valid. The IDLE/SHIFT state is implied by serial_valid.
- load_ready = reset && (!serial_valid || (shift_en && cnt == 0)). This is combinational and depends on shift_en; it does not depend on load_valid.
- Accept (load_valid && load_ready at a posedge): sr <= load_data; cnt <= WIDTH-1; serial_valid <= 1.
  - Latency: the first bit appears on serial_out in the cycle immediately after the accepting edge.
- serial_out = serial_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 0.
- Shift (serial_valid && shift_en && cnt != 0): sr shifts toward the output end (right if LSB-first, left if MSB-first), zero-fill; cnt <= cnt - 1.
- Last-bit consume (serial_valid && shift_en && cnt == 0):
  - If load_valid: treat as accept (gapless next frame, no idle cycle).
  - Else: serial_valid <= 0; sr <= 0.
- Stall (serial_valid && !shift_en): sr, cnt and serial_valid hold. serial_out and serial_last are stable. load_ready = 0.
- load_valid while load_ready = 0 has no effect. The upstream must hold load_data until accepted.
- serial_last = serial_valid && (cnt == 0).
- Frame length is exactly WIDTH consumed bits (bits where serial_valid && shift_en).
- shift_en while idle is ignored.
- Counter never wraps: decrements only while cnt != 0.

Decomposition:
- Shared package piso_pkg: constants for the MSB_FIRST encodings (PISO_LSB_FIRST = 0, PISO_MSB_FIRST = 1) and a CNT_W helper function. These are reused by the planned SIPO counterpart.
- No sub-module. Shift register, counter and handshake logic form one module.
- The bench instantiates the block with WIDTH = 8 and WIDTH = 12, in both bit orders.

Test Plan:
1. WIDTH = 8, LSB-first, reset released, shift_en = 1, load 8'b0101_1100 → serial_out over 8 cycles = 0,0,1,1,1,0,1,0. serial_valid is high for exactly 8 cycles. serial_last is high on the 8th cycle only. load_ready is low on cycles 1..7.
2. WIDTH = 8, MSB-first, load 8'hCC then 8'h5C back-to-back (load_valid held) → 16 consecutive valid cycles with no gap: 1,1,0,0,1,1,0,0,0,1,0,1,1,1,0,0. serial_last is high on cycles 8 and 16. load_ready is high on cycle 8.
3. Stall: LSB-first, load 8'h01, shift_en = 0 on cycles 2–3 → serial_out and cnt hold through the stall. Frame completes on cycle 10. Exactly 8 consumed bits, and the bit order is unchanged.
4. Reset mid-frame: load 8'hFF, drive reset = 0 at cycle 4 for one cycle → on the next cycle serial_out = 0, serial_valid = 0, load_ready = 1. A new load of 8'hA5 then serialises correctly from bit 0.
5. Ignored load: while busy with 8'h0F, pulse load_valid with 8'hF0 at cycle 3 (load_ready = 0) → the output is still 1,1,1,1,0,0,0,0 and the block returns to idle afterwards.
6. WIDTH = 12, LSB-first, load 12'hABC → 12 bits 0,0,1,1,1,1,0,1,0,1,0,1. serial_last is high on cycle 12 only.
